// File: rtl/grammer_pkg.sv
// rtl/grammer_pkg.sv - shared types and constants for the grammer_reader slice
package grammer_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    localparam logic [7:0] PH_QUARTER_LO = 8'h80;
    localparam logic [7:0] PH_ZERO_LO    = 8'hC0;

    typedef enum logic [1:0] {
        PH_RAW     = 2'd0,
        PH_HALF    = 2'd1,
        PH_QUARTER = 2'd2,
        PH_ZERO    = 2'd3
    } phase_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        phase_e            phase;
        logic              lossy;
        logic              err;
    } entry_t;

endpackage

// File: rtl/grammer_phase_decode.sv
// rtl/grammer_phase_decode.sv - combinational phase classification and unscaling of one producer word
module grammer_phase_decode #(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        in_cnt,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] dec_data,
    output logic [1:0]        dec_phase,
    output logic              dec_lossy,
    output logic              dec_err
);
    import grammer_pkg::*;

    phase_e phase;

    // The producer scaled down by its phase; shifting back loses the bits it dropped.
    always_comb begin
        phase     = PH_RAW;
        dec_data  = in_data;
        dec_lossy = 1'b0;
        dec_err   = 1'b0;
        if (in_cnt == 8'h00) begin
            phase = PH_RAW;
        end else if (in_cnt < PH_QUARTER_LO) begin
            phase     = PH_HALF;
            dec_data  = in_data << 1;
            dec_lossy = 1'b1;
            dec_err   = in_data[DATA_W-1];
        end else if (in_cnt < PH_ZERO_LO) begin
            phase     = PH_QUARTER;
            dec_data  = in_data << 2;
            dec_lossy = 1'b1;
            dec_err   = |in_data[DATA_W-1 -: 2];
        end else begin
            phase     = PH_ZERO;
            dec_data  = '0;
            dec_lossy = 1'b1;
            dec_err   = (in_data != '0);
        end
    end

    assign dec_phase = phase;

endmodule

// File: rtl/grammer_reader.sv
// rtl/grammer_reader.sv - decodes producer words and buffers them in a small circular array
module grammer_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [7:0]        in_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_phase,
    output logic              out_lossy,
    output logic              out_err,
    output logic [2:0]        level,
    output logic              overflow
);
    import grammer_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    entry_t            mem_q [DEPTH];
    entry_t            dec_entry;
    entry_t            head;
    logic [DATA_W-1:0] dec_data;
    logic [1:0]        dec_phase;
    logic              dec_lossy;
    logic              dec_err;
    logic              full, empty, push, pop;

    grammer_phase_decode #(.DATA_W(DATA_W)) u_decode (
        .in_cnt    (in_cnt),
        .in_data   (in_data),
        .dec_data  (dec_data),
        .dec_phase (dec_phase),
        .dec_lossy (dec_lossy),
        .dec_err   (dec_err)
    );

    assign dec_entry.data  = dec_data;
    assign dec_entry.phase = phase_e'(dec_phase);
    assign dec_entry.lossy = dec_lossy;
    assign dec_entry.err   = dec_err;

    // The extra wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        overflow_d = overflow_q || (in_valid && !in_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Only entry 0 is cleared so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= dec_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign out_data  = head.data;
    assign out_phase = head.phase;
    assign out_lossy = head.lossy;
    assign out_err   = head.err;
    assign level     = 3'(wr_ptr_q - rd_ptr_q);
    assign overflow  = overflow_q;

endmodule
